module_fetch_unit: RTL and testbench

MODULE_FETCH_UNIT -- requirements
Module: module_fetch_unit

---
 rtl/module_fetch_unit.sv | 113 +++++++++++
 tb/tb_module_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_fetch_unit.sv
// Instruction fetch unit: a three-state FSM (FETCH, EXEC, TRAP) that requests
// an instruction word, holds it for execute until released, then advances
// the PC sequentially or to a branch/jump target and counts retirements.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to send taken branches with a
// non-word-aligned target into TRAP (left only by reset). Without it the low
// two target bits are dropped when the target is loaded and TRAP is never
// entered.
module module_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] retired_o,
  output logic        misaligned_o
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        take_trap;

  // Clears the byte-offset bits so a loaded target is always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC selection and misaligned-target detection for the EXEC exit edge.
  always_comb begin
    take_trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc   = pc_src_i ? pc_target_i : pc_plus4;
    take_trap = pc_src_i && (pc_target_i[1:0] != 2'b00);
`else
    next_pc   = pc_src_i ? word_align(pc_target_i) : pc_plus4;
`endif
  end

  // Fetch/execute sequencing; reset abandons any fetch or stall in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      retired_q <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (!stall_i) begin
            retired_q <= retired_q + 32'd1;
            if (take_trap) begin
              state <= TRAP;
            end else begin
              pc_q  <= next_pc;
              state <= FETCH;
            end
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Request is gated by reset so nothing is issued while reset is held.
  assign imem_req_o    = (state == FETCH) && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = (state == EXEC);
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign retired_o     = retired_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned_o  = (state == TRAP);
`else
  assign misaligned_o  = 1'b0;
`endif

endmodule

// File: tb/tb_module_fetch_unit.sv
// Testbench for module_fetch_unit: table of fetch/execute transactions with a
// scoreboard of expected instruction/PC pairs, plus hand-written reset and
// misaligned-target sequences.
module tb_module_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        misaligned;

  module_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .pc_src_i      (pc_src),
    .pc_target_i   (pc_target),
    .stall_i       (stall),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .retired_o     (retired),
    .misaligned_o  (misaligned)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned wait_cyc;
    logic [31:0] rdata;
    logic        src;
    logic [31:0] target;
    int unsigned stall_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_trap;
  int unsigned c0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: FETCH (with wait states), ack, EXEC (with stalls), exit.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   k;
    imem_ack = 1'b0;
    for (int i = 0; i < int'(v.wait_cyc); i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    chk("ack_cycle_req", 32'(imem_req), 32'd1);
    chk("ack_cycle_addr", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    sb.push_back('{instr: v.rdata, pc: m_pc});
    tick();
    // stray ack/data while in EXEC must be ignored
    imem_rdata = 32'hDEAD_BEEF;
    k = 0;
    while (!instr_valid && k < 4) begin
      tick();
      k++;
    end
    chk("exec_valid", 32'(instr_valid), 32'd1);
    e = sb.pop_front();
    chk("exec_instr", instr, e.instr);
    chk("exec_pc", pc, e.pc);
    chk("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("exec_retired", retired, m_ret);
    stall = 1'b1;
    for (int i = 0; i < int'(v.stall_cyc); i++) begin
      pc_src    = i[0];
      pc_target = $urandom;
      tick();
      chk("stall_pc", pc, e.pc);
      chk("stall_instr", instr, e.instr);
      chk("stall_retired", retired, m_ret);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall     = 1'b0;
    pc_src    = v.src;
    pc_target = v.target;
    tick();
    imem_ack  = 1'b0;
    pc_src    = 1'b0;
    pc_target = 32'hCAFE_F00D;
    m_ret = m_ret + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (v.src && v.target[1:0] != 2'b00) m_trap = 1'b1;
    else m_pc = v.src ? v.target : m_pc + 32'd4;
`else
    m_pc = v.src ? {v.target[31:2], 2'b00} : m_pc + 32'd4;
`endif
    chk("exit_retired", retired, m_ret);
    chk("exit_addr", imem_addr, m_pc);
    chk("exit_valid", 32'(instr_valid), 32'd0);
    chk("exit_req", 32'(imem_req), 32'(!m_trap));
    chk("exit_misaligned", 32'(misaligned), 32'(m_trap));
  endtask

  initial begin
    vecs[0] = '{1, 32'h0050_0093, 1'b1, 32'h0000_0020, 0};
    vecs[1] = '{0, 32'h00A0_0113, 1'b1, 32'h0000_0080, 0};
    vecs[2] = '{3, 32'h0020_81B3, 1'b1, 32'h0000_0000, 5};
    vecs[3] = '{0, 32'h0000_0213, 1'b0, 32'h0000_0000, 0};
    vecs[4] = '{0, 32'h0012_0213, 1'b0, 32'h0000_0000, 0};
    vecs[5] = '{0, 32'h0022_0213, 1'b0, 32'h0000_0000, 0};
    vecs[6] = '{0, 32'h0000_006F, 1'b1, 32'hFFFF_FFFC, 1};
    vecs[7] = '{2, 32'h0040_0293, 1'b0, 32'h0000_0000, 0};

    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    pc_src     = 1'b0;
    pc_target  = 32'd0;
    stall      = 1'b0;
    m_trap     = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_pc", pc, 32'h0000_0100);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_retired", retired, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    imem_ack = 1'b1;
    tick();
    tick();
    chk("rst_held_req", 32'(imem_req), 32'd0);
    chk("rst_held_instr", instr, 32'h0000_0013);
    imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    m_pc  = 32'h0000_0100;
    m_ret = 32'd0;
    chk("first_req", 32'(imem_req), 32'd1);

    for (int n = 0; n < 8; n++) begin
      if (n == 3) c0 = cyc;
      run_vec(vecs[n]);
      if (n == 5) chk("three_instr_cycles", 32'(cyc - c0), 32'd6);
    end
    chk("wrap_pc", pc, 32'd0);

    // Reset in the middle of a fetch; an ack during reset is discarded.
    tick();
    rst = 1'b1;
    #1;
    chk("midfetch_rst_pc", pc, 32'h0000_0100);
    chk("midfetch_rst_retired", retired, 32'd0);
    chk("midfetch_rst_req", 32'(imem_req), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    tick();
    imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("stray_ack_instr", instr, 32'h0000_0013);
    chk("stray_ack_pc", pc, 32'h0000_0100);
    chk("stray_ack_req", 32'(imem_req), 32'd1);

    // Reset in the middle of a stall.
    imem_ack   = 1'b1;
    imem_rdata = 32'h00B0_0193;
    tick();
    imem_ack = 1'b0;
    stall    = 1'b1;
    tick();
    chk("midstall_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midstall_rst_valid", 32'(instr_valid), 32'd0);
    chk("midstall_rst_instr", instr, 32'h0000_0013);
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    m_pc  = 32'h0000_0100;
    m_ret = 32'd0;
    chk("midstall_after_req", 32'(imem_req), 32'd1);
    chk("midstall_after_addr", imem_addr, 32'h0000_0100);

    // Misaligned branch target.
    run_vec('{0, 32'h0000_0013, 1'b1, 32'h0000_0040, 0});
    run_vec('{0, 32'h0000_0063, 1'b1, 32'h0000_0102, 0});
`ifdef FETCH_MISALIGN_TRAP_EN
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_misaligned", 32'(misaligned), 32'd1);
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_valid", 32'(instr_valid), 32'd0);
      chk("trap_pc", pc, 32'h0000_0040);
      chk("trap_retired", retired, m_ret);
      chk("trap_instr", instr, 32'h0000_0063);
    end
    imem_ack = 1'b0;
`else
    chk("misaligned_target_addr", imem_addr, 32'h0000_0100);
    chk("misaligned_flag_low", 32'(misaligned), 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("trap_rst_misaligned", 32'(misaligned), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("trap_rst_req", 32'(imem_req), 32'd1);
    chk("trap_rst_pc", pc, 32'h0000_0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
